// File: rtl/execution_issue_ctrl.sv
// Execution issue controller: accepts decoded instructions, sequences single-cycle
// and two-cycle (MUL) operations into the Execution stage, hands results to
// writeback, and selects ALU-result forwarding for source operands.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        decode handshake
//   in_opcode, in_rd/ra/rb   offered instruction (opcode, dest, sources)
//   flush                    synchronous pipeline flush (highest priority)
//   ex_opcode, ex_valid      opcode and live flag for the Execution stage
//   s_mux_A, s_mux_B         operand select (1 = forwarded ALU result)
//   wb_valid/wb_ready        writeback handshake
//   wb_rd, wb_class          destination and class of completing instruction
//   wb_illegal               completing opcode unsupported
//   issue_count              accepted-instruction counter (wraps)
module execution_issue_ctrl #(
    parameter int unsigned REG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_opcode,
    input  logic [REG_W-1:0] in_rd,
    input  logic [REG_W-1:0] in_ra,
    input  logic [REG_W-1:0] in_rb,
    input  logic             flush,
    output logic [4:0]       ex_opcode,
    output logic             s_mux_A,
    output logic             s_mux_B,
    output logic             ex_valid,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [REG_W-1:0] wb_rd,
    output logic [1:0]       wb_class,
    output logic             wb_illegal,
    output logic [CNT_W-1:0] issue_count
);

    localparam logic [4:0] OP_NOP = 5'b11111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [4:0]       op_q;
    logic [REG_W-1:0] fwd_rd;
    logic             fwd_vld;
    logic             op_legal;
    logic             op_mul;
    logic             accept;
    logic             wb_fire;
    logic [REG_W-1:0] prod_rd;
    logic             prod_vld;

    // Opcode decode: classes 00/01/10 with sub-ops 000..010; sub-op 010 is MUL
    assign op_legal = (in_opcode[4:3] != 2'b11) && (in_opcode[2:0] <= 3'b010);
    assign op_mul   = op_legal && (in_opcode[2:0] == 3'b010);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake/stage outputs; flush overrides everything
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        ex_valid  = 1'b0;
        wb_valid  = 1'b0;
        ex_opcode = OP_NOP;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            MUL1: begin
                ex_valid  = 1'b1;
                ex_opcode = op_q;
                state_d   = EXEC;
            end
            EXEC: begin
                ex_valid  = 1'b1;
                wb_valid  = 1'b1;
                ex_opcode = op_q;
                in_ready  = wb_ready;
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            in_ready = 1'b0;
            wb_valid = 1'b0;
            state_d  = IDLE;
        end else if (in_valid && in_ready) begin
            state_d = op_mul ? MUL1 : EXEC;
        end
    end

    assign accept  = in_valid & in_ready;
    assign wb_fire = wb_valid & wb_ready;

    // Producer for forwarding: the instruction completing now, else the record
    assign prod_rd  = wb_fire ? wb_rd : fwd_rd;
    assign prod_vld = wb_fire ? ~wb_illegal : fwd_vld;

    // Latched instruction, forwarding selects, forwarding record and counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= OP_NOP;
            wb_rd       <= '0;
            wb_class    <= 2'b00;
            wb_illegal  <= 1'b0;
            s_mux_A     <= 1'b0;
            s_mux_B     <= 1'b0;
            fwd_rd      <= '0;
            fwd_vld     <= 1'b0;
            issue_count <= '0;
        end else begin
            if (accept) begin
                op_q        <= op_legal ? in_opcode : OP_NOP;
                wb_rd       <= in_rd;
                wb_class    <= in_opcode[4:3];
                wb_illegal  <= ~op_legal;
                s_mux_A     <= prod_vld && (in_ra == prod_rd);
                s_mux_B     <= prod_vld && (in_rb == prod_rd);
                issue_count <= issue_count + CNT_W'(1);
            end else if (state_d == IDLE) begin
                s_mux_A <= 1'b0;
                s_mux_B <= 1'b0;
            end
            if (flush) begin
                fwd_vld <= 1'b0;
            end else if (wb_fire) begin
                fwd_rd  <= wb_rd;
                fwd_vld <= ~wb_illegal;
            end
        end
    end

endmodule

// File: tb/tb_execution_issue_ctrl.sv
// Directed testbench for execution_issue_ctrl (REG_W=4, CNT_W=4 so counter
// wrap is reachable quickly).
module tb_execution_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_opcode;
    logic [3:0] in_rd;
    logic [3:0] in_ra;
    logic [3:0] in_rb;
    logic       flush;
    logic [4:0] ex_opcode;
    logic       s_mux_A;
    logic       s_mux_B;
    logic       ex_valid;
    logic       wb_valid;
    logic       wb_ready;
    logic [3:0] wb_rd;
    logic [1:0] wb_class;
    logic       wb_illegal;
    logic [3:0] issue_count;

    int n_chk  = 0;
    int n_pass = 0;

    execution_issue_ctrl #(.REG_W(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_ra      (in_ra),
        .in_rb      (in_rb),
        .flush      (flush),
        .ex_opcode  (ex_opcode),
        .s_mux_A    (s_mux_A),
        .s_mux_B    (s_mux_B),
        .ex_valid   (ex_valid),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_class   (wb_class),
        .wb_illegal (wb_illegal),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [3:0] rd,
                         input logic [3:0] ra, input logic [3:0] rb);
        in_valid  = v;
        in_opcode = op;
        in_rd     = rd;
        in_ra     = ra;
        in_rb     = rb;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
        drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
        tick(); tick();
        check("rst_exop",   32'(ex_opcode), 32'h1f);
        check("rst_exv",    32'(ex_valid), 0);
        check("rst_wbv",    32'(wb_valid), 0);
        check("rst_wbrd",   32'(wb_rd), 0);
        check("rst_cls",    32'(wb_class), 0);
        check("rst_ill",    32'(wb_illegal), 0);
        check("rst_smux",   32'({s_mux_A, s_mux_B}), 0);
        check("rst_cnt",    32'(issue_count), 0);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", 32'(in_ready), 1);

        // ADD rd=3: result one cycle after accept, then back to idle
        drive(1'b1, 5'b00000, 4'd3, 4'd0, 4'd0);
        #1 check("add_rdy", 32'(in_ready), 1);
        tick(); drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
        #1;
        check("add_exop", 32'(ex_opcode), 0);
        check("add_wbv",  32'(wb_valid), 1);
        check("add_wbrd", 32'(wb_rd), 3);
        check("add_cls",  32'(wb_class), 0);
        check("add_cnt",  32'(issue_count), 1);
        tick();
        check("add_idle_exv", 32'(ex_valid), 0);
        check("add_idle_op",  32'(ex_opcode), 32'h1f);

        // Fixed MUL rd=4 then ADD rd=6 ra=4 held through MUL1
        drive(1'b1, 5'b01010, 4'd4, 4'd1, 4'd1);
        tick(); drive(1'b1, 5'b00000, 4'd6, 4'd4, 4'd9);
        #1;
        check("mul1_rdy",  32'(in_ready), 0);
        check("mul1_exv",  32'(ex_valid), 1);
        check("mul1_wbv",  32'(wb_valid), 0);
        check("mul1_exop", 32'(ex_opcode), 32'h0a);
        tick();
        check("mul_wbv",  32'(wb_valid), 1);
        check("mul_wbrd", 32'(wb_rd), 4);
        check("mul_cls",  32'(wb_class), 1);
        check("mul_rdy",  32'(in_ready), 1);
        tick(); drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
        #1;
        check("b2b_wbv",  32'(wb_valid), 1);
        check("b2b_wbrd", 32'(wb_rd), 6);
        check("b2b_exop", 32'(ex_opcode), 0);
        check("b2b_fwd",  32'({s_mux_A, s_mux_B}), 32'b10);
        check("b2b_cnt",  32'(issue_count), 3);
        tick();
        check("idle_smux", 32'({s_mux_A, s_mux_B}), 0);

        // ADD rd=5, SUB ra=5 rb=2 rd=8, ADD ra=7 rb=8
        drive(1'b1, 5'b00000, 4'd5, 4'd0, 4'd0);
        tick(); drive(1'b1, 5'b00001, 4'd8, 4'd5, 4'd2);
        tick();
        check("sub_exop", 32'(ex_opcode), 1);
        check("sub_fwd",  32'({s_mux_A, s_mux_B}), 32'b10);
        drive(1'b1, 5'b00000, 4'd1, 4'd7, 4'd8);
        tick(); drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
        #1 check("unrel_fwd", 32'({s_mux_A, s_mux_B}), 32'b01);
        tick();

        // Illegal 00111 rd=10, follower ra=10 must not forward
        drive(1'b1, 5'b00111, 4'd10, 4'd0, 4'd0);
        tick(); drive(1'b1, 5'b00000, 4'd2, 4'd10, 4'd1);
        #1;
        check("ill_exop", 32'(ex_opcode), 32'h1f);
        check("ill_flag", 32'(wb_illegal), 1);
        check("ill_wbv",  32'(wb_valid), 1);
        check("ill_wbrd", 32'(wb_rd), 10);
        tick(); drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
        #1;
        check("ill_nofwd", 32'({s_mux_A, s_mux_B}), 0);
        check("ill_clr",   32'(wb_illegal), 0);
        tick();
        // Class 11 with MUL sub-op is illegal and therefore single-cycle
        drive(1'b1, 5'b11010, 4'd3, 4'd0, 4'd0);
        tick(); drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
        #1;
        check("ill11_wbv", 32'(wb_valid), 1);
        check("ill11_flg", 32'(wb_illegal), 1);
        check("ill11_cls", 32'(wb_class), 3);
        tick();

        // Vector MUL rd=7 with writeback stalled for 3 cycles
        drive(1'b1, 5'b10010, 4'd7, 4'd0, 4'd0);
        wb_ready = 1'b0;
        tick(); drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
        #1;
        check("vmul1_wbv",  32'(wb_valid), 0);
        check("vmul1_exop", 32'(ex_opcode), 32'h12);
        tick(); drive(1'b1, 5'b00000, 4'd9, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_wbv",  32'(wb_valid), 1);
            check("stall_rdy",  32'(in_ready), 0);
            check("stall_out",  32'({ex_opcode, wb_rd, wb_class}), 32'({5'h12, 4'd7, 2'd2}));
            check("stall_cnt",  32'(issue_count), 10);
            tick();
        end
        wb_ready = 1'b1;
        drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
        tick();
        check("stall_done", 32'(wb_valid), 0);

        // Flush during MUL1 discards the MUL and the forwarding record
        drive(1'b1, 5'b01010, 4'd2, 4'd0, 4'd0);
        tick(); drive(1'b1, 5'b00000, 4'd0, 4'd0, 4'd0);
        flush = 1'b1;
        #1 check("flush_rdy", 32'(in_ready), 0);
        tick(); flush = 1'b0; drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
        #1;
        check("flush_wbv", 32'(wb_valid), 0);
        check("flush_exv", 32'(ex_valid), 0);
        check("flush_cnt", 32'(issue_count), 11);
        tick();
        check("flush_wbv2", 32'(wb_valid), 0);
        drive(1'b1, 5'b00000, 4'd0, 4'd7, 4'd0);
        tick(); drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
        #1 check("flush_nofwd", 32'(s_mux_A), 0);
        tick();

        // Back-to-back ADDs to 17 accepts (wraps to 1), then reset mid-stream
        drive(1'b1, 5'b00000, 4'd1, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) tick();
        check("wrap_cnt", 32'(issue_count), 1);
        check("wrap_wbv", 32'(wb_valid), 1);
        rst = 1'b1;
        #1;
        check("arst_cnt", 32'(issue_count), 0);
        check("arst_wbv", 32'(wb_valid), 0);
        drive(1'b0, 5'd0, 4'd0, 4'd0, 4'd0);
        tick(); rst = 1'b0;
        #1 check("arst_rdy", 32'(in_ready), 1);
        tick();
        check("arst_nowb", 32'(wb_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/execution_issue_ctrl.md
EXECUTION_ISSUE_CTRL -- requirements
Module: execution_issue_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 4, meaning register-index width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning issue-counter width.
REQ-003 SHALL have ports, one per line: name direction width meaning.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decode offers an instruction.
- in_ready  output  1  controller accepts; handshake = in_valid & in_ready.
- in_opcode  input  5  5-bit execution opcode.
- in_rd / in_ra / in_rb  input  REG_W each  destination and source register indices.
- flush  input  1  synchronous pipeline flush.
- ex_opcode  output  5  opcode driven to the Execution stage.
- s_mux_A / s_mux_B  output  1 each  operand select: 0 = decode operand, 1 = forwarded ALU result.
- ex_valid  output  1  Execution stage holds a live instruction.
- wb_valid  output  1  result ready for writeback.
- wb_ready  input  1  writeback accepts; handshake = wb_valid & wb_ready.
- wb_rd  output  REG_W  destination of the completing instruction.
- wb_class  output  2  opcode[4:3]: 00 int, 01 fixed, 10 vector.
- wb_illegal  output  1  completing opcode unsupported.
- issue_count  output  CNT_W  number of accepted instructions.

Function
REQ-004 Legal opcodes SHALL be 00000–00010, 01000–01010 and 10000–10010; all others are illegal.
REQ-005 MUL SHALL be defined as a legal opcode with opcode[2:0]=010.
REQ-006 The FSM SHALL have three states: IDLE, MUL1 and EXEC.
REQ-007 In IDLE: in_ready=1; ex_opcode=11111; ex_valid=0; wb_valid=0.
REQ-008 On acceptance in IDLE: next state SHALL be MUL1 for MUL, otherwise EXEC; opcode, rd and class SHALL be latched.
REQ-009 In MUL1: ex_valid=1; wb_valid=0; in_ready=0; ex_opcode=latched opcode; next state SHALL be EXEC unconditionally.
REQ-010 In EXEC: ex_valid=1; wb_valid=1; ex_opcode=latched opcode; in_ready=wb_ready.
REQ-011 In EXEC with wb_ready=0: state and all outputs SHALL hold.
REQ-012 In EXEC with wb_ready=1 and in_valid=1: the next instruction SHALL be accepted in the same cycle (back-to-back), going to MUL1 or EXEC.
REQ-013 In EXEC with wb_ready=1 and in_valid=0: next state SHALL be IDLE.
REQ-014 Latency, accept to wb_valid: 1 cycle for ADD/SUB; 2 cycles for MUL.
REQ-015 Sustained throughput with wb_ready=1 SHALL be 1 instr/cycle for ADD/SUB and 1 instr/2 cycles for MUL.
REQ-016 An illegal opcode SHALL behave as a 1-cycle op with ex_opcode=11111 and wb_illegal=1.
REQ-017 Forwarding record (fwd_rd, fwd_vld) SHALL update on each wb handshake: fwd_rd=wb_rd; fwd_vld=~wb_illegal.
REQ-018 On acceptance, s_mux_A SHALL be registered as 1 iff in_ra equals the producer rd and the producer is valid; s_mux_B likewise with in_rb.
- Producer = the instruction completing in that same cycle if a wb handshake occurs; otherwise the forwarding record.
REQ-019 s_mux_A/B SHALL hold their value until the next acceptance, and SHALL be 0 in IDLE.
REQ-020 issue_count SHALL increment by 1 per accepted instruction and wrap modulo 2^CNT_W.
REQ-021 flush=1 SHALL take priority over all other events.
- next state IDLE; fwd_vld=0; any in-flight result discarded without a wb handshake; no acceptance that cycle; issue_count unchanged.

Reset
REQ-022 While rst=1, asynchronously: state=IDLE; ex_opcode=11111; ex_valid=0; wb_valid=0; wb_rd=0; wb_class=0; wb_illegal=0; s_mux_A=0; s_mux_B=0; fwd_vld=0; issue_count=0.
REQ-023 rst asserted mid-MUL1 or in EXEC SHALL abort the instruction with no wb_valid pulse after release.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-025 ADD 00000, rd=3, at cycle 0 with wb_ready=1 -> ex_opcode=00000 and wb_valid=1, wb_rd=3, wb_class=00 at cycle 1; IDLE at cycle 2.
REQ-026 Fixed MUL 01010 then int ADD back-to-back -> in_ready=0 during MUL1; MUL wb at +2; ADD accepted in the MUL EXEC cycle; ADD wb at +3.
REQ-027 ADD rd=5 followed immediately by SUB ra=5, rb=2 -> s_mux_A=1 and s_mux_B=0 for the SUB; a later unrelated op with ra=7 -> s_mux_A=0.
REQ-028 Opcode 00111 -> ex_opcode=11111 and wb_illegal=1; a following op with ra equal to that rd -> s_mux_A=0.
REQ-029 wb_ready=0 for 3 cycles in EXEC -> outputs stable and in_ready=0; flush in MUL1 -> IDLE with no wb_valid.
REQ-030 With CNT_W=4, 17 accepted ops -> issue_count=1; rst asserted mid-stream -> issue_count=0 immediately.
